// File: rtl/bus_datapath.sv
// Single-bus datapath: GPR file, PC, IR, MAR, MDR on one shared bus with one-hot drive enables,
// plus a read/write handshake that moves data between memory and MDR.
//
// state    | meaning
// ST_IDLE  | no memory transaction; rd_start/wr_start accepted
// ST_READ  | read outstanding; mem_ack captures mem_rdata into MDR
// ST_WRITE | write outstanding; mem_ack completes it
module bus_datapath #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int PC_STEP = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [NREGS-1:0] reg_in,
    input  logic [NREGS-1:0] reg_out,
    input  logic             pci,
    input  logic             pco,
    input  logic             pc_inc,
    input  logic             iri,
    input  logic             iro,
    input  logic             mari,
    input  logic             mdri,
    input  logic             mdro,
    input  logic             immo,
    input  logic [WIDTH-1:0] imm,
    input  logic             rd_start,
    input  logic             wr_start,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             mdr_valid,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] ir_q,
    output logic             bus_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] bus_or;
    logic [WIDTH-1:0] aux_src [4];
    logic [3:0]       aux_en;
    logic             seen;
    logic             multi;

    assign aux_src[0] = pc_q;
    assign aux_src[1] = ir_q;
    assign aux_src[2] = mdr_q;
    assign aux_src[3] = imm;
    assign aux_en     = {immo, mdro, iro, pco};

    // OR all enabled sources, then suppress the result if more than one drove.
    always_comb begin
        bus_or = '0;
        seen   = 1'b0;
        multi  = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            if (reg_out[k]) begin
                multi  = multi | seen;
                seen   = 1'b1;
                bus_or = bus_or | regs[k];
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (aux_en[j]) begin
                multi  = multi | seen;
                seen   = 1'b1;
                bus_or = bus_or | aux_src[j];
            end
        end
        bus = (seen && !multi) ? bus_or : '0;
    end

    assign busy      = (state != ST_IDLE);
    assign mem_req   = busy;
    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else begin
            // A register driving the bus keeps its value even if its load enable is also set.
            for (int k = 0; k < NREGS; k++) begin
                if (reg_in[k] && !reg_out[k]) regs[k] <= bus;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            state     <= ST_IDLE;
            mdr_valid <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            bus_err   <= bus_err | multi;
            mdr_valid <= 1'b0;
            if (pci)         pc_q <= bus;
            else if (pc_inc) pc_q <= pc_q + WIDTH'(PC_STEP);
            if (iri)         ir_q <= bus;
            if (mari && !busy) mar_q <= bus;
            if (state == ST_READ && mem_ack) begin
                mdr_q     <= mem_rdata;
                mdr_valid <= 1'b1;
            end else if (mdri && !busy) begin
                mdr_q <= bus;
            end
            case (state)
                ST_IDLE: begin
                    if (rd_start)      state <= ST_READ;
                    else if (wr_start) state <= ST_WRITE;
                end
                ST_READ, ST_WRITE: begin
                    if (mem_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed plus randomized bench for bus_datapath, checked against a register-level
// reference model (plain arrays and arithmetic) held in the bench.
module tb_bus_datapath;

    localparam int W = 32;
    localparam int N = 16;

    logic          clock = 1'b0;
    logic          clear;
    logic [N-1:0]  reg_in, reg_out;
    logic          pci, pco, pc_inc, iri, iro, mari, mdri, mdro, immo;
    logic [W-1:0]  imm;
    logic          rd_start, wr_start, mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          mem_req, mem_we, busy, mdr_valid, bus_err;
    logic [W-1:0]  mem_addr, mem_wdata, bus, pc_q, ir_q;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_pc, m_ir, m_mar, m_mdr;

    bus_datapath #(.WIDTH(W), .NREGS(N), .PC_STEP(4)) dut (
        .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
        .pci(pci), .pco(pco), .pc_inc(pc_inc), .iri(iri), .iro(iro),
        .mari(mari), .mdri(mdri), .mdro(mdro), .immo(immo), .imm(imm),
        .rd_start(rd_start), .wr_start(wr_start), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .mdr_valid(mdr_valid), .bus(bus), .pc_q(pc_q), .ir_q(ir_q),
        .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        reg_in = '0; reg_out = '0; pci = 0; pco = 0; pc_inc = 0; iri = 0; iro = 0;
        mari = 0; mdri = 0; mdro = 0; immo = 0; rd_start = 0; wr_start = 0; mem_ack = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_regs[k] = '0;
        m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0;
    endtask

    // Drive imm onto the bus into the selected destinations for one cycle.
    task automatic load_imm(input logic [W-1:0] v, input logic to_pc, input logic to_mar, input logic to_mdr);
        quiet();
        imm = v; immo = 1; pci = to_pc; mari = to_mar; mdri = to_mdr;
        step();
        quiet();
    endtask

    initial begin
        logic [W-1:0] v, rdat;
        logic [N-1:0] dmask;
        int src, lat;
        bit is_rd;

        quiet();
        imm = '0; mem_rdata = '0; clear = 0;
        model_reset();
        step(); step();
        clear = 1;
        check("rst_pc", pc_q, '0);
        check("rst_ir", ir_q, '0);
        check("rst_req", {31'b0, mem_req}, '0);
        check("rst_busy", {31'b0, busy}, '0);
        check("rst_err", {31'b0, bus_err}, '0);
        check("rst_bus", bus, '0);
        check("rst_mar", mem_addr, '0);
        check("rst_mdr", mem_wdata, '0);

        // imm -> R3, R3 -> R5
        imm = 32'h1234; immo = 1; reg_in[3] = 1; #1;
        check("imm_bus", bus, 32'h1234);
        step(); quiet();
        m_regs[3] = 32'h1234;
        reg_out[3] = 1; reg_in[5] = 1; step(); quiet();
        m_regs[5] = 32'h1234;
        reg_out[5] = 1; #1;
        check("r5_copy", bus, 32'h1234);
        check("no_err", {31'b0, bus_err}, '0);
        quiet();

        // random single-source transfers into random register sets and IR
        for (int i = 0; i < 40; i++) begin
            quiet();
            src = $urandom_range(0, N);
            dmask = N'($urandom);
            if (src == N) begin
                v = $urandom; imm = v; immo = 1;
            end else begin
                v = m_regs[src]; reg_out[src] = 1;
            end
            reg_in = dmask;
            iri = $urandom_range(0, 1);
            #1;
            check("rnd_bus", bus, v);
            for (int k = 0; k < N; k++) if (dmask[k]) m_regs[k] = v;
            if (iri) m_ir = v;
            step();
        end
        quiet();
        for (int k = 0; k < N; k++) begin
            reg_out = '0; reg_out[k] = 1; #1;
            check($sformatf("reg%0d", k), bus, m_regs[k]);
        end
        quiet();
        check("ir", ir_q, m_ir);
        iro = 1; #1;
        check("ir_bus", bus, m_ir);
        quiet();

        // PC wrap and priority
        load_imm(32'hFFFF_FFFC, 1, 0, 0);
        check("pc_load", pc_q, 32'hFFFF_FFFC);
        pc_inc = 1; step(); quiet();
        check("pc_wrap", pc_q, 32'h0);
        imm = 32'h40; immo = 1; pci = 1; pc_inc = 1; step(); quiet();
        check("pc_prio", pc_q, 32'h40);
        m_pc = 32'h40;
        for (int i = 0; i < 5; i++) begin
            pc_inc = $urandom_range(0, 1);
            if (pc_inc) m_pc = m_pc + 4;
            step();
        end
        quiet();
        check("pc_incs", pc_q, m_pc);
        pco = 1; #1;
        check("pc_bus", bus, m_pc);
        quiet();

        // ack while idle has no effect
        mem_ack = 1; mem_rdata = 32'hAAAA_5555; step(); quiet();
        check("idle_ack_v", {31'b0, mdr_valid}, '0);
        check("idle_ack_b", {31'b0, busy}, '0);

        // read with three busy cycles; mari/mdri during busy ignored
        load_imm(32'h100, 0, 1, 0);
        check("mar", mem_addr, 32'h100);
        rd_start = 1; step(); quiet();
        for (int i = 0; i < 3; i++) begin
            check("rd_req", {31'b0, mem_req}, 1);
            check("rd_we", {31'b0, mem_we}, 0);
            check("rd_addr", mem_addr, 32'h100);
            imm = 32'h200; immo = 1; mari = 1; mdri = 1;
            if (i == 2) begin mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; end
            step(); quiet();
        end
        check("rd_done", {31'b0, mem_req}, 0);
        check("rd_valid", {31'b0, mdr_valid}, 1);
        check("rd_mdr", mem_wdata, 32'hDEAD_BEEF);
        check("rd_mar", mem_addr, 32'h100);
        step();
        check("rd_vpulse", {31'b0, mdr_valid}, 0);
        mdro = 1; #1;
        check("mdr_bus", bus, 32'hDEAD_BEEF);
        quiet();

        // write with two busy cycles
        load_imm(32'h55, 0, 0, 1);
        wr_start = 1; step(); quiet();
        for (int i = 0; i < 2; i++) begin
            check("wr_we", {31'b0, mem_we}, 1);
            check("wr_req", {31'b0, mem_req}, 1);
            check("wr_data", mem_wdata, 32'h55);
            if (i == 1) begin mem_ack = 1; mem_rdata = 32'h9999; end
            step(); quiet();
        end
        check("wr_done", {31'b0, mem_req}, 0);
        check("wr_nvalid", {31'b0, mdr_valid}, 0);
        check("wr_mdr", mem_wdata, 32'h55);
        m_mdr = 32'h55; m_mar = 32'h100;

        // random transactions with random latency
        for (int t = 0; t < 8; t++) begin
            v = $urandom;
            load_imm(v, 0, 1, 0);
            m_mar = v;
            is_rd = $urandom_range(0, 1);
            lat = $urandom_range(1, 4);
            rdat = $urandom;
            rd_start = is_rd; wr_start = !is_rd; step(); quiet();
            for (int c = 0; c < lat; c++) begin
                check("rnd_busy", {31'b0, busy}, 1);
                check("rnd_we", {31'b0, mem_we}, {31'b0, !is_rd});
                check("rnd_addr", mem_addr, m_mar);
                check("rnd_wdata", mem_wdata, m_mdr);
                if (c == lat - 1) begin mem_ack = 1; mem_rdata = rdat; end
                step(); quiet();
            end
            if (is_rd) m_mdr = rdat;
            check("rnd_idle", {31'b0, busy}, 0);
            check("rnd_valid", {31'b0, mdr_valid}, {31'b0, is_rd});
            check("rnd_mdr", mem_wdata, m_mdr);
        end

        // contention: bus forced to 0, sticky error
        reg_out[1] = 1; pco = 1; #1;
        check("cont_bus", bus, '0);
        step(); quiet();
        check("cont_err", {31'b0, bus_err}, 1);
        step(); step();
        check("err_sticky", {31'b0, bus_err}, 1);

        // both starts -> read only; then reset mid-transaction
        rd_start = 1; wr_start = 1; step(); quiet();
        check("both_req", {31'b0, mem_req}, 1);
        check("both_we", {31'b0, mem_we}, 0);
        clear = 0; immo = 1; imm = 32'h77; mari = 1; step(); quiet();
        clear = 1;
        model_reset();
        check("abort_req", {31'b0, mem_req}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_err", {31'b0, bus_err}, 0);
        check("abort_mar", mem_addr, '0);
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D; step(); quiet();
        check("late_valid", {31'b0, mdr_valid}, 0);
        check("late_mdr", mem_wdata, '0);
        check("late_busy", {31'b0, busy}, 0);
        reg_out[3] = 1; #1;
        check("rst_r3", bus, m_regs[3]);
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
